// File: rtl/exmem_exec_pkg.sv
// Shared CPU constants: ALU operation codes, multiplier FSM states, EX/MEM control bundle.
// Also holds the single-cycle ALU function used by the execute stage.
package exmem_exec_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_e;

    typedef struct packed {
        logic [4:0] rd_addr;
        logic [1:0] mem;
        logic       wb;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Unknown codes (including MUL, which never takes this path) yield 0.
    function automatic logic [31:0] alu_1cyc(input logic [3:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exmem_exec_mul_iter.sv
// Radix-2 shift-add multiplier: 32 steps, low 32 bits of A*B.
// Latency: start edge + 32 step cycles; done is high during the final step, product valid then.
// No backpressure: start is only honoured while idle.
module mul_iter
    import exmem_exec_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    mul_state_e  state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] acc_q;
    logic [31:0] acc_next;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
    assign busy     = (state_q == ST_MUL);
    assign done     = (state_q == ST_MUL) && (cnt_q == 5'd31);
    // Product includes the final step so the caller can latch it on the completing edge.
    assign product  = acc_next;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_MUL;
            ST_MUL:  if (cnt_q == 5'd31) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE) begin
                if (start) begin
                    mcand_q  <= a;
                    mplier_q <= b;
                    acc_q    <= 32'd0;
                    cnt_q    <= 5'd0;
                end
            end else begin
                acc_q    <= acc_next;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 5'd1;
            end
        end
    end

endmodule

// File: rtl/exmem_exec.sv
// Execute stage with EX/MEM output latch; add/sub/and/or in one cycle, multiply via mul_iter.
// Latency: 1 edge for ALU ops, 33 edges (accept + 32 steps) for multiply; stall_o holds ID/EX meanwhile.
module exmem_exec
    import exmem_exec_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] val1_i,
    input  logic [31:0] val2_i,
    input  logic [31:0] imm_i,
    input  logic        ALUSrc_i,
    input  logic [3:0]  ALUCtrl_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [1:0]  Mem_i,
    input  logic        WB_i,
    output logic        stall_o,
    output logic [31:0] alu_o,
    output logic [31:0] wdata_o,
    output logic [4:0]  rd_addr_o,
    output logic [1:0]  Mem_o,
    output logic        WB_o
);

    logic        mul_busy;
    logic        mul_done;
    logic        mul_start;
    logic [31:0] mul_product;
    logic [31:0] op_b;
    ctrl_t       ctrl_in;
    ctrl_t       ctrl_cap_q;
    ctrl_t       ctrl_q;

    assign op_b      = ALUSrc_i ? imm_i : val2_i;
    assign ctrl_in   = '{rd_addr: rd_addr_i, mem: Mem_i, wb: WB_i};
    assign mul_start = valid_i && (ALUCtrl_i == ALU_MUL) && !mul_busy;
    // The completing step drops stall so ID/EX can advance on the same edge the result lands.
    assign stall_o   = mul_start || (mul_busy && !mul_done);

    mul_iter u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (mul_start),
        .a       (val1_i),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_cap_q <= CTRL_BUBBLE;
            ctrl_q     <= CTRL_BUBBLE;
            alu_o      <= 32'd0;
            wdata_o    <= 32'd0;
        end else begin
            if (mul_start) ctrl_cap_q <= ctrl_in;

            if (mul_done) begin
                alu_o  <= mul_product;
                ctrl_q <= ctrl_cap_q;
            end else if (stall_o || !valid_i) begin
                ctrl_q <= CTRL_BUBBLE;
            end else begin
                alu_o   <= alu_1cyc(ALUCtrl_i, val1_i, op_b);
                wdata_o <= val2_i;
                ctrl_q  <= ctrl_in;
            end
        end
    end

    assign rd_addr_o = ctrl_q.rd_addr;
    assign Mem_o     = ctrl_q.mem;
    assign WB_o      = ctrl_q.wb;

endmodule

// File: doc/exmem_exec.md
EXMEM_EXEC -- requirements
Module: exmem_exec

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: valid_i  in  1  ID/EX latch holds a real instruction this cycle.
REQ-004 SHALL have: val1_i, val2_i, imm_i  in  32 each  rs1 data, rs2 data, immediate from ID/EX.
REQ-005 SHALL have: ALUSrc_i  in  1  1 selects imm_i as operand B, 0 selects val2_i.
REQ-006 SHALL have: ALUCtrl_i  in  4  operation code from ID/EX.
REQ-007 SHALL have: rd_addr_i  in  5; Mem_i  in  2; WB_i  in  1  control fields passed downstream.
REQ-008 SHALL have: stall_o  out  1  hold fetch/decode and the ID/EX latch this cycle.
REQ-009 SHALL have: alu_o  out  32  registered execute result.
REQ-010 SHALL have: wdata_o  out  32  registered val2_i (store data).
REQ-011 SHALL have: rd_addr_o  out  5; Mem_o  out  2; WB_o  out  1  registered control to MEM stage.

Function
REQ-012 SHALL decode ALUCtrl_i: 0010 add, 0110 sub (A-B), 0000 AND, 0001 OR, 1111 multiply; any other code SHALL yield result 0 with controls passed unchanged.
REQ-013 SHALL compute add/sub/AND/OR in one cycle: outputs valid at the rising edge ending the cycle valid_i is high.
REQ-014 SHALL implement multiply as an iterative radix-2 shift-add unit producing the low 32 bits of A*B (two's-complement wraps identically to signed low-half product).
REQ-015 SHALL use states IDLE and MUL with a 5-bit step counter.
REQ-016 IDLE: valid_i=1 with ALUCtrl_i=1111 SHALL capture A, B, rd/Mem/WB, clear accumulator, counter:=0, go to MUL.
REQ-017 MUL: each cycle SHALL add shifted multiplicand if current multiplier bit is 1, then shift, counter+1.
REQ-018 MUL with counter=31 SHALL complete the final step, load alu_o with the product and registered controls, return to IDLE at that edge.
REQ-019 stall_o SHALL be combinational: 1 when (IDLE and valid_i and ALUCtrl_i=1111) or (MUL and counter!=31), else 0.
REQ-020 A multiply SHALL therefore hold stall_o high for 32 cycles and deliver its result exactly 33 edges after acceptance (counting the accept edge).
REQ-021 During every cycle with stall_o=1 the output latch SHALL load a bubble: WB_o=0, Mem_o=00, rd_addr_o=0, alu_o and wdata_o unchanged.
REQ-022 valid_i=0 in IDLE SHALL load a bubble as in REQ-021.
REQ-023 Inputs in MUL SHALL be ignored; operands used are only those captured in REQ-016.
REQ-024 Back-to-back multiplies SHALL be accepted on the cycle immediately after REQ-018 completes, with no idle gap.
REQ-025 Multiply by zero SHALL still take the full 32 steps (fixed latency).

Reset
REQ-026 rst_i=0 SHALL immediately force state IDLE, counter 0, accumulator 0, alu_o=0, wdata_o=0, rd_addr_o=0, Mem_o=00, WB_o=0, regardless of clock.
REQ-027 Reset asserted mid-multiply SHALL abandon the operation; no partial result SHALL reach alu_o; stall_o SHALL be 0 while in reset unless REQ-019 holds from IDLE.
REQ-028 First edge after rst_i rises SHALL behave as a normal IDLE cycle.

Structure
REQ-029 ALUCtrl codes (ADD, SUB, AND, OR, MUL) and state encodings SHALL be constants in the shared CPU package used by the ID/EX decoder.
REQ-030 The iterative multiplier SHALL be a sub-module mul_iter (start, A, B -> busy, done, product); exmem_exec SHALL own the FSM-facing stall logic and output latch.

Verification
REQ-031 add: val1=5, val2=7, ALUSrc=0, ALUCtrl=0010, rd=3, WB=1 -> next edge alu_o=12, rd_addr_o=3, WB_o=1, stall_o never high.
REQ-032 sub with imm: val1=10, imm=-3, ALUSrc=1, ALUCtrl=0110 -> alu_o=13; AND/OR 0xF0F0_F0F0 with 0x0FF0_0FF0 -> 0x00F0_00F0 / 0xFFF0_FFF0.
REQ-033 mul: val1=6, val2=-7, ALUCtrl=1111, rd=9 -> stall_o high 32 cycles, WB_o=0 throughout, then alu_o=0xFFFF_FFD6, rd_addr_o=9, WB_o=1 on the 33rd edge.
REQ-034 back-to-back mul 0x10000*0x10000 then 3*4 -> alu_o=0 then 12, second accepted the cycle after first completes, total 66 edges.
REQ-035 reset pulse at step 15 of 6*7 -> outputs all zero, IDLE, no 42 ever appears; subsequent add 1+1 -> alu_o=2.
REQ-036 ALUCtrl=0101 with WB=1, rd=4 -> alu_o=0, WB_o=1, rd_addr_o=4.
